ahb_lite_mem_tester: RTL and testbench

- Self-checking AHB-Lite master that sits directly upstream of ahb_lite_sdram and drives its slave port.
- On start it writes WORD_COUNT 32-bit words of a deterministic pattern from BASE_ADDR, reads them back, and compares them.
- It reports pass/fail, the error count and the first failing address.
- Used in system bring-up and as a bench stimulus source, replacing hand-written master tasks.

---
 rtl/ahb_lite_mem_tester_if.sv | 24 ++
 rtl/ahb_lite_mem_tester.sv | 150 +++++++++++++++
 tb/tb_ahb_lite_mem_tester.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_mem_tester_if.sv
// AHB-Lite bus bundle between the memory tester (master) and the SDRAM
// controller slave port.
interface ahb_lite_mem_tester_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_mem_tester.sv
// Self-checking AHB-Lite master: writes an address-derived pattern, reads it
// back, and reports pass/fail, error count and first failing address.
module ahb_lite_mem_tester #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WORD_COUNT   = 16,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
  parameter int unsigned ERR_WIDTH    = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [31:0]          first_err_addr,
  ahb_lite_mem_tester_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE} state_t;
  typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_NONSEQ = 2'b10} htrans_t;

  localparam logic [15:0] LAST = 16'(WORD_COUNT - 1);

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return BASE_ADDR + {14'd0, idx, 2'b00};
  endfunction

  state_t         state;
  htrans_t        htrans_q;
  logic [31:0]    haddr_q;
  logic [31:0]    hwdata_q;
  logic           hwrite_q;
  logic           hsel_q;
  logic [15:0]    a_idx;
  logic [15:0]    d_idx;
  logic           dph;
  logic           dph_write;
  logic           reissue;

  logic [31:0]    d_addr;
  logic           xfer_done;
  logic           xfer_err;
  logic [ERR_WIDTH-1:0] err_next;

  assign bus.HSEL   = hsel_q;
  assign bus.HADDR  = haddr_q;
  assign bus.HBURST = 3'b000;
  assign bus.HSIZE  = 3'b010;
  assign bus.HTRANS = htrans_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HWDATA = hwdata_q;

  always_comb begin
    d_addr    = word_addr(d_idx);
    xfer_done = dph && bus.HREADY;
    xfer_err  = xfer_done &&
                (bus.HRESP || (!dph_write && (bus.HRDATA != (d_addr ^ PATTERN_SEED))));
    err_next  = err_count;
    if (xfer_err && (err_count != '1))
      err_next = err_count + ERR_WIDTH'(1);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state          <= IDLE;
      htrans_q       <= TR_IDLE;
      haddr_q        <= '0;
      hwdata_q       <= '0;
      hwrite_q       <= 1'b0;
      hsel_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      a_idx          <= '0;
      d_idx          <= '0;
      dph            <= 1'b0;
      dph_write      <= 1'b0;
      reissue        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            htrans_q       <= TR_NONSEQ;
            haddr_q        <= BASE_ADDR;
            hwrite_q       <= 1'b1;
            hsel_q         <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            a_idx          <= '0;
            dph            <= 1'b0;
            reissue        <= 1'b0;
          end
        end
        default: begin
          if (xfer_done) begin
            err_count <= err_next;
            if (xfer_err && (err_count == '0))
              first_err_addr <= d_addr;
          end
          if (!bus.HREADY) begin
            // First ERROR cycle: withdraw the overlapped address phase; a_idx
            // still names it, so it is simply re-driven once the error ends.
            if (dph && bus.HRESP && (htrans_q == TR_NONSEQ)) begin
              htrans_q <= TR_IDLE;
              reissue  <= 1'b1;
            end
          end else begin
            dph       <= (htrans_q == TR_NONSEQ);
            dph_write <= hwrite_q;
            d_idx     <= a_idx;
            if (htrans_q == TR_NONSEQ) begin
              if (hwrite_q)
                hwdata_q <= word_addr(a_idx) ^ PATTERN_SEED;
              if (a_idx == LAST) begin
                htrans_q <= TR_IDLE;
                state    <= (state == WRITE) ? WDRAIN : RDRAIN;
              end else begin
                a_idx   <= a_idx + 16'd1;
                haddr_q <= word_addr(a_idx + 16'd1);
              end
            end else if (reissue) begin
              htrans_q <= TR_NONSEQ;
              reissue  <= 1'b0;
            end else if (state == WDRAIN) begin
              state    <= READ;
              htrans_q <= TR_NONSEQ;
              haddr_q  <= BASE_ADDR;
              hwrite_q <= 1'b0;
              a_idx    <= '0;
            end else if (state == RDRAIN) begin
              state  <= DONE;
              hsel_q <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_next == '0);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Directed bench for ahb_lite_mem_tester (4 words) against a small AHB-Lite
// slave model with optional wait states, read corruption and ERROR injection.
module tb_ahb_lite_mem_tester;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  ahb_lite_mem_tester_if bus ();

  ahb_lite_mem_tester #(
    .BASE_ADDR   (32'h0000_0000),
    .WORD_COUNT  (4),
    .PATTERN_SEED(32'hA5A5_0000),
    .ERR_WIDTH   (16)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .bus           (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Slave model controls
  logic        rand_waits = 1'b0;
  logic        err_en     = 1'b0;
  logic [31:0] err_addr   = 32'h0;
  logic        bad_en     = 1'b0;
  logic [31:0] bad_addr   = 32'h0;

  logic [31:0] mem [16];
  logic        dp_v, dp_w, err_second, err_hit;
  logic [31:0] dp_a;
  int unsigned wait_left;

  always_comb begin
    err_hit    = dp_v && err_en && dp_w && (dp_a == err_addr);
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    if (dp_v) begin
      if (err_hit) begin
        bus.HRESP  = 1'b1;
        bus.HREADY = err_second;
      end else begin
        bus.HREADY = (wait_left == 0);
      end
    end
    bus.HRDATA = (bad_en && (dp_a == bad_addr)) ? 32'h0 : mem[dp_a[5:2]];
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_v       <= 1'b0;
      dp_w       <= 1'b0;
      dp_a       <= 32'h0;
      wait_left  <= 0;
      err_second <= 1'b0;
    end else if (bus.HREADY) begin
      if (dp_v && dp_w && !err_hit) mem[dp_a[5:2]] <= bus.HWDATA;
      dp_v       <= (bus.HTRANS == 2'b10);
      dp_w       <= bus.HWRITE;
      dp_a       <= bus.HADDR;
      wait_left  <= rand_waits ? $urandom_range(5, 0) : 0;
      err_second <= 1'b0;
    end else if (err_hit) begin
      err_second <= 1'b1;
    end else begin
      wait_left <= wait_left - 1;
    end
  end

  // Bus-hold monitor for plain wait states (ERROR cycles excluded)
  logic        p_rdy = 1'b1, p_resp = 1'b0, p_write = 1'b0;
  logic [1:0]  p_trans = 2'b00;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
  int          stall_cycles = 0, stall_bad = 0;

  always @(posedge HCLK) begin
    p_rdy   <= bus.HREADY;
    p_resp  <= bus.HRESP;
    p_trans <= bus.HTRANS;
    p_addr  <= bus.HADDR;
    p_write <= bus.HWRITE;
    p_wdata <= bus.HWDATA;
  end

  always @(negedge HCLK) begin
    if (HRESETn && busy && !p_rdy && !p_resp) begin
      stall_cycles <= stall_cycles + 1;
      if ((bus.HADDR !== p_addr) || (bus.HTRANS !== p_trans) ||
          (bus.HWRITE !== p_write) || (bus.HWDATA !== p_wdata))
        stall_bad <= stall_bad + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  tr_trans [64];
  logic [31:0] tr_addr  [64];
  logic        tr_busy1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start, then samples every cycle until done; cyc counts cycles
  // after the start cycle. restart_at re-pulses start while busy.
  task automatic run(input int unsigned limit, input int unsigned restart_at,
                     output int unsigned cyc);
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    cyc = 1;
    tr_trans[1] = bus.HTRANS;
    tr_addr[1]  = bus.HADDR;
    tr_busy1    = busy;
    while (done !== 1'b1 && cyc < limit) begin
      start = (cyc == restart_at);
      @(negedge HCLK);
      cyc++;
      if (cyc < 64) begin
        tr_trans[cyc] = bus.HTRANS;
        tr_addr[cyc]  = bus.HADDR;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int unsigned cyc;
    logic [11:0] nonseq_bits;

    HRESETn = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_done",   32'(done), 32'h0);
    chk("rst_pass",   32'(pass), 32'h0);
    chk("rst_err",    32'(err_count), 32'h0);
    chk("rst_first",  first_err_addr, 32'h0);
    chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("rst_haddr",  bus.HADDR, 32'h0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_hsel",   32'(bus.HSEL), 32'h0);
    chk("hburst",     32'(bus.HBURST), 32'h0);
    chk("hsize",      32'(bus.HSIZE), 32'h2);

    // Zero-wait run: latency, NONSEQ pattern and written data
    run(40, 0, cyc);
    chk("lat_cycles", cyc, 32'd11);
    chk("lat_busy1",  32'(tr_busy1), 32'h1);
    nonseq_bits = '0;
    for (int k = 1; k <= 11; k++) nonseq_bits[k] = tr_trans[k][1];
    chk("lat_nonseq", 32'(nonseq_bits), 32'h3DE);
    chk("lat_raddr0", tr_addr[6], 32'h0);
    chk("lat_raddr3", tr_addr[9], 32'hC);
    chk("lat_done",   32'(done), 32'h1);
    chk("lat_pass",   32'(pass), 32'h1);
    chk("lat_err",    32'(err_count), 32'h0);
    chk("mem0", mem[0], 32'hA5A5_0000);
    chk("mem1", mem[1], 32'hA5A5_0004);
    chk("mem2", mem[2], 32'hA5A5_0008);
    chk("mem3", mem[3], 32'hA5A5_000C);

    // start while busy is ignored
    run(40, 3, cyc);
    chk("busy_start_cycles", cyc, 32'd11);
    chk("busy_start_pass",   32'(pass), 32'h1);

    // Corrupted read data at address 8
    bad_en = 1'b1; bad_addr = 32'h8;
    run(40, 0, cyc);
    bad_en = 1'b0;
    chk("badrd_done",  32'(done), 32'h1);
    chk("badrd_err",   32'(err_count), 32'h1);
    chk("badrd_first", first_err_addr, 32'h8);
    chk("badrd_pass",  32'(pass), 32'h0);
    chk("badrd_busy",  32'(busy), 32'h0);

    // ERROR response on the write to address 4
    err_en = 1'b1; err_addr = 32'h4;
    run(60, 0, cyc);
    err_en = 1'b0;
    chk("err_cyc3_trans", 32'(tr_trans[3]), 32'h2);
    chk("err_cyc3_addr",  tr_addr[3], 32'h8);
    chk("err_cyc4_trans", 32'(tr_trans[4]), 32'h0);
    chk("err_cyc5_trans", 32'(tr_trans[5]), 32'h2);
    chk("err_cyc5_addr",  tr_addr[5], 32'h8);
    chk("err_cycles",     cyc, 32'd13);
    chk("err_err",        32'(err_count), 32'h1);
    chk("err_first",      first_err_addr, 32'h4);
    chk("err_pass",       32'(pass), 32'h0);
    chk("err_mem2",       mem[2], 32'hA5A5_0008);

    // Random wait states
    rand_waits = 1'b1;
    run(400, 0, cyc);
    rand_waits = 1'b0;
    chk("wait_done",   32'(done), 32'h1);
    chk("wait_pass",   32'(pass), 32'h1);
    chk("wait_err",    32'(err_count), 32'h0);
    chk("wait_stalls", 32'(stall_cycles > 0), 32'h1);
    chk("wait_hold",   32'(stall_bad), 32'h0);

    // Reset mid-READ after an error has been counted
    bad_en = 1'b1; bad_addr = 32'h0;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (8) @(negedge HCLK);
    chk("mid_err_before", 32'(err_count), 32'h1);
    chk("mid_busy_before", 32'(busy), 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(busy), 32'h0);
    chk("mid_rst_done",   32'(done), 32'h0);
    chk("mid_rst_err",    32'(err_count), 32'h0);
    chk("mid_rst_first",  first_err_addr, 32'h0);
    chk("mid_rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("mid_rst_haddr",  bus.HADDR, 32'h0);
    chk("mid_rst_hwdata", bus.HWDATA, 32'h0);
    chk("mid_rst_hsel",   32'(bus.HSEL), 32'h0);
    bad_en = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    run(40, 0, cyc);
    chk("post_rst_cycles", cyc, 32'd11);
    chk("post_rst_pass",   32'(pass), 32'h1);
    chk("post_rst_err",    32'(err_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
